// File: rtl/interrupt_controller.sv
// Interrupt controller: queues frame ticks and keyboard scan codes and presents
// one interrupt at a time to the screen processor via an IRQ/IACK/IEND handshake.
module interrupt_controller #(
    parameter int KFIFO_DEPTH = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FRAME_TICK,
    input  logic       KBD_STROBE,
    input  logic [7:0] KBD_CODE,
    output logic [1:0] INT_IRQ,
    input  logic       INT_IACK,
    input  logic       INT_IEND,
    output logic [7:0] KBD_KEY,
    output logic       BUSY,
    output logic       TIMER_OVERRUN,
    output logic       KBD_OVERFLOW
);

    localparam int AW = $clog2(KFIFO_DEPTH);
    // Counter only needs to reach TIMEOUT-1: the abort fires during the N-th cycle.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(KFIFO_DEPTH);

    localparam logic [1:0] IRQ_FRAME = 2'b00;
    localparam logic [1:0] IRQ_KBD   = 2'b01;
    localparam logic [1:0] IRQ_NONE  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_SERVICE} state_t;

    state_t          state, state_n;
    logic [1:0]      code, code_n;
    logic            load_key;
    logic            tick_pending;
    logic [7:0]      fifo_mem [KFIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count;
    logic [TW-1:0]   svc_cnt;
    logic            fifo_full, fifo_empty, timeout_hit, done, tick_clr, pop, push_ok;

    assign fifo_full   = (count == FULL_CNT);
    assign fifo_empty  = (count == '0);
    assign timeout_hit = (TIMEOUT != 0) && (svc_cnt == TO_LAST);
    assign done        = (state == S_SERVICE) && (INT_IEND || timeout_hit);
    assign tick_clr    = (state == S_PRESENT) && INT_IACK && (code == IRQ_FRAME);
    assign pop         = done && (code == IRQ_KBD);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok     = KBD_STROBE && (!fifo_full || pop);

    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        code_n   = code;
        load_key = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick_pending) begin
                    state_n = S_PRESENT;
                    code_n  = IRQ_FRAME;
                end else if (!fifo_empty) begin
                    state_n  = S_PRESENT;
                    code_n   = IRQ_KBD;
                    load_key = 1'b1;
                end
            end
            S_PRESENT: if (INT_IACK) state_n = S_SERVICE;
            S_SERVICE: if (done)     state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            code          <= IRQ_NONE;
            INT_IRQ       <= IRQ_NONE;
            KBD_KEY       <= '0;
            BUSY          <= 1'b0;
            TIMER_OVERRUN <= 1'b0;
            KBD_OVERFLOW  <= 1'b0;
            tick_pending  <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            svc_cnt       <= '0;
        end else begin
            code    <= code_n;
            INT_IRQ <= (state_n == S_PRESENT) ? code_n : IRQ_NONE;
            BUSY    <= (state_n != S_IDLE);
            if (load_key) KBD_KEY <= fifo_mem[rd_ptr];

            tick_pending <= FRAME_TICK | (tick_pending & ~tick_clr);
            if (FRAME_TICK && tick_pending && !tick_clr) TIMER_OVERRUN <= 1'b1;
            if (KBD_STROBE && !push_ok)                  KBD_OVERFLOW  <= 1'b1;

            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Held at zero outside SERVICE so it restarts on every entry.
            svc_cnt <= (state == S_SERVICE) ? svc_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) fifo_mem[wr_ptr] <= KBD_CODE;
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios plus random traffic, every
// cycle compared against a queue-based reference model.
module tb_interrupt_controller;

    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       FRAME_TICK = 1'b0, KBD_STROBE = 1'b0, INT_IACK = 1'b0, INT_IEND = 1'b0;
    logic [7:0] KBD_CODE = '0;
    logic [1:0] INT_IRQ;
    logic [7:0] KBD_KEY;
    logic       BUSY, TIMER_OVERRUN, KBD_OVERFLOW;

    interrupt_controller #(.KFIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET(RESET), .FRAME_TICK(FRAME_TICK), .KBD_STROBE(KBD_STROBE),
        .KBD_CODE(KBD_CODE), .INT_IRQ(INT_IRQ), .INT_IACK(INT_IACK), .INT_IEND(INT_IEND),
        .KBD_KEY(KBD_KEY), .BUSY(BUSY), .TIMER_OVERRUN(TIMER_OVERRUN),
        .KBD_OVERFLOW(KBD_OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0;

    // Reference model: 0 = waiting, 1 = presenting, 2 = in service
    int         m_st, m_svc;
    logic [1:0] m_code;
    logic [7:0] m_key;
    bit         m_tp, m_ovr, m_ofl;
    logic [7:0] m_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_svc = 0; m_code = 2'b11; m_key = '0;
        m_tp = 0; m_ovr = 0; m_ofl = 0;
        m_q.delete();
    endtask

    task automatic model_cmp();
        chk("irq",  {30'd0, INT_IRQ}, (m_st == 1) ? {30'd0, m_code} : 32'd3);
        chk("key",  {24'd0, KBD_KEY}, {24'd0, m_key});
        chk("busy", {31'd0, BUSY}, {31'd0, (m_st != 0)});
        chk("ovr",  {31'd0, TIMER_OVERRUN}, {31'd0, m_ovr});
        chk("ofl",  {31'd0, KBD_OVERFLOW}, {31'd0, m_ofl});
    endtask

    task automatic model_step(input bit tick, input bit strobe, input logic [7:0] code,
                              input bit iack, input bit iend);
        bit clr, done, pop;
        clr  = (m_st == 1) && iack && (m_code == 2'b00);
        done = (m_st == 2) && (iend || (m_svc + 1 == TO));
        pop  = done && (m_code == 2'b01);
        case (m_st)
            0: if (m_tp) begin
                   m_st = 1; m_code = 2'b00;
               end else if (m_q.size() > 0) begin
                   m_st = 1; m_code = 2'b01; m_key = m_q[0];
               end
            1: if (iack) begin m_st = 2; m_svc = 0; end
            default: if (done) m_st = 0; else m_svc++;
        endcase
        if (tick && m_tp && !clr) m_ovr = 1;
        m_tp = tick || (m_tp && !clr);
        if (pop) void'(m_q.pop_front());
        if (strobe) begin
            if (m_q.size() < DEPTH) m_q.push_back(code);
            else                    m_ofl = 1;
        end
    endtask

    task automatic step(input bit tick, input bit strobe, input logic [7:0] code,
                        input bit iack, input bit iend);
        FRAME_TICK = tick; KBD_STROBE = strobe; KBD_CODE = code;
        INT_IACK = iack; INT_IEND = iend;
        @(posedge CLK);
        model_step(tick, strobe, code, iack, iend);
        #1;
        FRAME_TICK = 0; KBD_STROBE = 0; KBD_CODE = '0; INT_IACK = 0; INT_IEND = 0;
        model_cmp();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0);
    endtask

    task automatic do_reset();
        RESET = 1;
        FRAME_TICK = 0; KBD_STROBE = 0; INT_IACK = 0; INT_IEND = 0;
        @(posedge CLK);
        model_reset();
        #1;
        RESET = 0;
        model_cmp();
        chk("rst_irq",  {30'd0, INT_IRQ}, 32'd3);
        chk("rst_key",  {24'd0, KBD_KEY}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_ovr",  {31'd0, TIMER_OVERRUN}, 32'd0);
        chk("rst_ofl",  {31'd0, KBD_OVERFLOW}, 32'd0);
    endtask

    task automatic wait_irq(input string tag, input logic [1:0] exp);
        for (int i = 0; i < 20 && INT_IRQ !== exp; i++) idle(1);
        chk(tag, {30'd0, INT_IRQ}, {30'd0, exp});
    endtask

    initial begin
        model_reset();
        do_reset();
        idle(2);

        // single frame tick: visible two edges after the tick, gone after IACK
        step(1, 0, 8'h00, 0, 0);
        chk("t1_lat1", {30'd0, INT_IRQ}, 32'd3);
        idle(1);
        chk("t1_irq00", {30'd0, INT_IRQ}, 32'd0);
        idle(2);
        chk("t1_hold", {30'd0, INT_IRQ}, 32'd0);
        step(0, 0, 8'h00, 1, 0);
        chk("t1_ack", {30'd0, INT_IRQ}, 32'd3);
        chk("t1_busy", {31'd0, BUSY}, 32'd1);
        idle(4);
        step(0, 0, 8'h00, 0, 1);
        chk("t1_end", {31'd0, BUSY}, 32'd0);

        // keyboard code held through IACK, FIFO empty afterwards
        step(0, 1, 8'h20, 0, 0);
        idle(1);
        chk("t2_irq01", {30'd0, INT_IRQ}, 32'd1);
        chk("t2_key", {24'd0, KBD_KEY}, 32'h20);
        step(0, 0, 8'h00, 1, 0);
        chk("t2_key_ack", {24'd0, KBD_KEY}, 32'h20);
        step(0, 0, 8'h00, 0, 1);
        idle(3);
        chk("t2_empty", {30'd0, INT_IRQ}, 32'd3);

        // frame beats keyboard in the same cycle
        step(1, 1, 8'h41, 0, 0);
        idle(1);
        chk("t3_frame", {30'd0, INT_IRQ}, 32'd0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 1);
        chk("t3_gap", {30'd0, INT_IRQ}, 32'd3);
        idle(1);
        chk("t3_kbd", {30'd0, INT_IRQ}, 32'd1);
        chk("t3_key", {24'd0, KBD_KEY}, 32'h41);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 1);

        // overflow: fifth code dropped, first four served in order
        for (int i = 1; i <= 5; i++) step(0, 1, 8'(i), 0, 0);
        chk("t4_ofl", {31'd0, KBD_OVERFLOW}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            wait_irq("t4_irq", 2'b01);
            chk("t4_key", {24'd0, KBD_KEY}, i);
            step(0, 0, 8'h00, 1, 0);
            step(0, 0, 8'h00, 0, 1);
        end
        idle(3);
        chk("t4_drain", {30'd0, INT_IRQ}, 32'd3);

        // reset while in service flushes everything, including sticky flags
        step(0, 1, 8'h77, 0, 0);
        step(0, 1, 8'h78, 0, 0);
        wait_irq("t5_irq", 2'b01);
        step(0, 0, 8'h00, 1, 0);
        chk("t5_svc", {31'd0, BUSY}, 32'd1);
        do_reset();
        idle(3);
        chk("t5_flush", {30'd0, INT_IRQ}, 32'd3);

        // two ticks before IACK: overrun, only one frame interrupt
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        chk("t6_ovr", {31'd0, TIMER_OVERRUN}, 32'd1);
        wait_irq("t6_irq", 2'b00);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 1);
        idle(3);
        chk("t6_once", {30'd0, INT_IRQ}, 32'd3);

        // tick coinciding with the frame IACK: no overrun, second interrupt follows
        do_reset();
        step(1, 0, 8'h00, 0, 0);
        wait_irq("t7_irq", 2'b00);
        step(1, 0, 8'h00, 1, 0);
        chk("t7_noovr", {31'd0, TIMER_OVERRUN}, 32'd0);
        step(0, 0, 8'h00, 0, 1);
        idle(1);
        chk("t7_again", {30'd0, INT_IRQ}, 32'd0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 1);

        // service timeout after the 8th cycle pops the code
        step(0, 1, 8'h5a, 0, 0);
        wait_irq("t8_irq", 2'b01);
        step(0, 0, 8'h00, 1, 0);
        idle(TO - 1);
        chk("t8_still", {31'd0, BUSY}, 32'd1);
        idle(1);
        chk("t8_abort", {31'd0, BUSY}, 32'd0);
        idle(3);
        chk("t8_popped", {30'd0, INT_IRQ}, 32'd3);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(15) == 0, $urandom_range(5) == 0, 8'($urandom),
                 $urandom_range(2) == 0, $urandom_range(4) == 0);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
